// File: rtl/apb_mon_pkg.sv
// Shared types and helpers for the APB protocol monitor.
package apb_mon_pkg;

  // Number of distinct protocol violations the monitor tracks.
  localparam int N_ERR = 6;

  // Monitor view of the transfer phase.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Bit position of each violation in err_flags; also the err_code value.
  typedef enum logic [2:0] {
    ERR_ENABLE_NO_SEL   = 3'd0,
    ERR_MULTI_SEL       = 3'd1,
    ERR_NO_ENABLE       = 3'd2,
    ERR_ENABLE_IN_SETUP = 3'd3,
    ERR_UNSTABLE        = 3'd4,
    ERR_TIMEOUT         = 3'd5
  } err_idx_e;

  // Index of the lowest set violation bit (0 when none is set).
  function automatic logic [2:0] lowest_err(input logic [N_ERR-1:0] v);
    logic [2:0] code;
    code = '0;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (v[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/apb_protocol_monitor_if.sv
// APB bus signal bundle with master, slave and passive monitor views.
interface apb_protocol_monitor_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PREADY, PSLVERR
  );

  // Passive observer: every signal is an input.
  modport monitor (
    input PSEL, PENABLE, PADDR, PWRITE, PWDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coinciding
// with clear is kept, so the count restarts at one.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count register: reset, clear-with-retain, or saturating increment.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= {{(WIDTH-1){1'b0}}, inc};
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol monitor: follows each transfer through
// SETUP/ACCESS, flags protocol violations (sticky flags plus a one-cycle
// pulse) and keeps saturating counts of transfers, slave errors and
// violation cycles.
//
// The state register records the phase of the previous sampled cycle.
// SETUP means "last cycle was a setup cycle", so the first access cycle
// is evaluated while in SETUP. ACCESS with done_reg set means the last
// cycle completed a transfer; it then behaves like IDLE for the next
// sample, which lets back-to-back transfers start without a gap.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  apb_protocol_monitor_if.monitor bus,
  input  logic                  clear,
  output logic                  busy,
  output logic [N_ERR-1:0]      err_flags,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [CNT_WIDTH-1:0]  slverr_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // Wait counter only needs to reach TIMEOUT_CYCLES before saturating.
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES);

  state_t                state_reg, state_next;
  logic                  done_reg, done_next;
  logic                  to_fired_reg, to_fired_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [NUM_SLAVES-1:0] cap_sel_reg, cap_sel_next;
  logic [ADDR_WIDTH-1:0] cap_addr_reg, cap_addr_next;
  logic                  cap_write_reg, cap_write_next;
  logic [DATA_WIDTH-1:0] cap_wdata_reg, cap_wdata_next;

  logic [N_ERR-1:0]      err_vec;
  logic [N_ERR-1:0]      err_flags_reg;
  logic                  err_valid_reg;
  logic [2:0]            err_code_reg;

  logic                  sel_any;
  logic                  mismatch;
  logic                  idle_eval;
  logic                  in_access;
  logic                  start_setup;
  logic                  complete;

  assign sel_any  = |bus.PSEL;
  assign mismatch = (bus.PSEL   != cap_sel_reg)   ||
                    (bus.PADDR  != cap_addr_reg)  ||
                    (bus.PWRITE != cap_write_reg) ||
                    (bus.PWDATA != cap_wdata_reg);

  // Phase tracking, violation detection and transfer completion.
  always_comb begin
    state_next     = state_reg;
    done_next      = done_reg;
    to_fired_next  = to_fired_reg;
    wait_cnt_next  = wait_cnt_reg;
    cap_sel_next   = cap_sel_reg;
    cap_addr_next  = cap_addr_reg;
    cap_write_next = cap_write_reg;
    cap_wdata_next = cap_wdata_reg;
    err_vec        = '0;
    idle_eval      = 1'b0;
    in_access      = 1'b0;
    start_setup    = 1'b0;
    complete       = 1'b0;

    // Bus-wide checks, independent of the phase.
    err_vec[ERR_ENABLE_NO_SEL] = bus.PENABLE & ~sel_any;
    err_vec[ERR_MULTI_SEL]     = ($countones(bus.PSEL) > 1);

    // Classify the current sample from the previous phase.
    case (state_reg)
      IDLE:    idle_eval = 1'b1;
      SETUP: begin
        if (bus.PENABLE) begin
          in_access = 1'b1;
        end else begin
          err_vec[ERR_NO_ENABLE] = 1'b1;
          if (sel_any) start_setup = 1'b1;
          else         state_next  = IDLE;
        end
      end
      ACCESS: begin
        if (done_reg) idle_eval = 1'b1;
        else          in_access = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Between transfers: a new select either opens a setup phase or is
    // illegally accompanied by PENABLE.
    if (idle_eval) begin
      state_next = IDLE;
      done_next  = 1'b0;
      if (sel_any && !bus.PENABLE)     start_setup = 1'b1;
      else if (sel_any && bus.PENABLE) err_vec[ERR_ENABLE_IN_SETUP] = 1'b1;
    end

    // Access cycle: check stability, completion and the wait budget.
    if (in_access) begin
      state_next = ACCESS;
      done_next  = 1'b0;
      if (!sel_any) begin
        err_vec[ERR_UNSTABLE] = 1'b1;
        state_next            = IDLE;
      end else begin
        if (mismatch) err_vec[ERR_UNSTABLE] = 1'b1;
        if (bus.PENABLE && bus.PREADY) begin
          complete  = 1'b1;
          done_next = 1'b1;
        end else if (!bus.PREADY) begin
          if ((wait_cnt_reg == WAIT_LAST) && !to_fired_reg) begin
            err_vec[ERR_TIMEOUT] = 1'b1;
            to_fired_next        = 1'b1;
          end
          if (wait_cnt_reg != WAIT_MAX) wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
    end

    // New setup phase: capture the address/control for the stability check.
    if (start_setup) begin
      state_next     = SETUP;
      done_next      = 1'b0;
      to_fired_next  = 1'b0;
      wait_cnt_next  = '0;
      cap_sel_next   = bus.PSEL;
      cap_addr_next  = bus.PADDR;
      cap_write_next = bus.PWRITE;
      cap_wdata_next = bus.PWDATA;
    end
  end

  // FSM and captured-transfer registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg     <= IDLE;
      done_reg      <= 1'b0;
      to_fired_reg  <= 1'b0;
      wait_cnt_reg  <= '0;
      cap_sel_reg   <= '0;
      cap_addr_reg  <= '0;
      cap_write_reg <= 1'b0;
      cap_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      done_reg      <= done_next;
      to_fired_reg  <= to_fired_next;
      wait_cnt_reg  <= wait_cnt_next;
      cap_sel_reg   <= cap_sel_next;
      cap_addr_reg  <= cap_addr_next;
      cap_write_reg <= cap_write_next;
      cap_wdata_reg <= cap_wdata_next;
    end
  end

  // Error reporting: sticky flags (clear keeps same-cycle violations),
  // one-cycle pulse and lowest-index code.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_flags_reg <= '0;
      err_valid_reg <= 1'b0;
      err_code_reg  <= '0;
    end else begin
      err_flags_reg <= clear ? err_vec : (err_flags_reg | err_vec);
      err_valid_reg <= |err_vec;
      err_code_reg  <= (|err_vec) ? lowest_err(err_vec) : 3'd0;
    end
  end

  // Counters: index 0 transfers, 1 slave errors, 2 violation cycles.
  logic [2:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_val [3];

  assign cnt_inc = {|err_vec, complete & bus.PSLVERR, complete};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH (CNT_WIDTH)
      ) u_cnt (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .clr    (clear),
        .inc    (cnt_inc[gi]),
        .count  (cnt_val[gi])
      );
    end
  endgenerate

  assign busy         = (state_reg != IDLE);
  assign err_flags    = err_flags_reg;
  assign err_valid    = err_valid_reg;
  assign err_code     = err_code_reg;
  assign xfer_count   = cnt_val[0];
  assign slverr_count = cnt_val[1];
  assign err_count    = cnt_val[2];

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed bench for apb_protocol_monitor: one task per scenario with
// hand-computed expected values.
module tb_apb_protocol_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          clear;
  logic          busy;
  logic [5:0]    err_flags;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [CW-1:0] xfer_count;
  logic [CW-1:0] slverr_count;
  logic [CW-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  apb_protocol_monitor_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_protocol_monitor #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .bus          (bus),
    .clear        (clear),
    .busy         (busy),
    .err_flags    (err_flags),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .xfer_count   (xfer_count),
    .slverr_count (slverr_count),
    .err_count    (err_count)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One clock: sample on the rising edge, then settle just after it.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.PSEL    = '0;
    bus.PENABLE = 1'b0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
  endtask

  task automatic bus_setup(input logic [NS-1:0] sel, input logic [AW-1:0] addr,
                           input logic wr, input logic [DW-1:0] wdata);
    bus.PSEL    = sel;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wdata;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
  endtask

  task automatic apply_reset();
    HRESET = 1'b1;
    clear  = 1'b0;
    bus_idle();
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    clear  = 1'b0;
    bus.PSEL = 4'b0011; bus.PENABLE = 1'b1; bus.PADDR = '0; bus.PWRITE = 1'b0;
    bus.PWDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    tick();
    tick();
    bus_idle();
    HRESET = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_tests++; if (err_flags !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", err_flags); end
    n_tests++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", err_valid); end
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", err_code); end
    n_tests++; if ({xfer_count, slverr_count, err_count} !== '0) begin n_fail++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", xfer_count, slverr_count, err_count); end
    $display("[TB] reset: checked idle outputs");
  endtask

  task automatic test_write();
    apply_reset();
    bus_setup(4'b0001, 32'h10, 1'b1, 32'hCAFE_0001);
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_setup: got %0b want 1", busy); end
    bus.PENABLE = 1'b1; bus.PREADY = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_access: got %0b want 1", busy); end
    n_tests++; if (xfer_count !== 4'd1) begin n_fail++; $display("FAIL write_xfer: got %0d want 1", xfer_count); end
    bus_idle();
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end: got %0b want 0", busy); end
    n_tests++; if (err_flags !== 6'b0 || err_count !== 4'd0) begin n_fail++;
      $display("FAIL write_noerr: got flags %b count %0d want 000000 0", err_flags, err_count); end
    $display("[TB] write 0x10 zero-wait: xfer_count=%0d", xfer_count);
  endtask

  task automatic test_read_wait();
    apply_reset();
    bus_setup(4'b0010, 32'h20, 1'b0, 32'h0);
    tick();
    bus.PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (busy !== 1'b1 || xfer_count !== 4'd0) begin n_fail++;
      $display("FAIL read_waiting: got busy %0b xfer %0d want 1 0", busy, xfer_count); end
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
    tick();
    n_tests++; if (xfer_count !== 4'd1) begin n_fail++; $display("FAIL read_xfer: got %0d want 1", xfer_count); end
    n_tests++; if (slverr_count !== 4'd1) begin n_fail++; $display("FAIL read_slverr: got %0d want 1", slverr_count); end
    bus_idle();
    tick();
    n_tests++; if (err_flags !== 6'b0 || err_count !== 4'd0) begin n_fail++;
      $display("FAIL read_noerr: got flags %b count %0d want 000000 0", err_flags, err_count); end
    $display("[TB] read 0x20 three waits with slverr: slverr_count=%0d", slverr_count);
  endtask

  task automatic test_unstable();
    apply_reset();
    bus_setup(4'b0001, 32'h10, 1'b1, 32'h1234);
    tick();
    bus.PENABLE = 1'b1; bus.PREADY = 1'b1; bus.PADDR = 32'h14;
    tick();
    n_tests++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL unstable_valid: got %0b want 1", err_valid); end
    n_tests++; if (err_code !== 3'd4) begin n_fail++; $display("FAIL unstable_code: got %0d want 4", err_code); end
    n_tests++; if (err_flags !== 6'b010000) begin n_fail++; $display("FAIL unstable_flags: got %b want 010000", err_flags); end
    bus_idle();
    tick();
    n_tests++; if (err_valid !== 1'b0 || err_flags !== 6'b010000) begin n_fail++;
      $display("FAIL unstable_sticky: got valid %0b flags %b want 0 010000", err_valid, err_flags); end
    $display("[TB] addr change 0x10->0x14 in access: err_code=4");
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pulse_at = -1;
    apply_reset();
    bus_setup(4'b0100, 32'h40, 1'b0, 32'h0);
    tick();
    bus.PENABLE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (err_valid === 1'b1) begin pulses++; pulse_at = i; end
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
    n_tests++; if (pulse_at != TO - 1) begin n_fail++; $display("FAIL timeout_cycle: got %0d want %0d", pulse_at, TO - 1); end
    n_tests++; if (err_code !== 3'd5 && pulses == 0) begin n_fail++; $display("FAIL timeout_seen: got code %0d want 5", err_code); end
    bus.PREADY = 1'b1;
    tick();
    n_tests++; if (xfer_count !== 4'd1) begin n_fail++; $display("FAIL timeout_xfer: got %0d want 1", xfer_count); end
    bus_idle();
    tick();
    n_tests++; if (err_flags !== 6'b100000 || err_count !== 4'd1) begin n_fail++;
      $display("FAIL timeout_flags: got flags %b count %0d want 100000 1", err_flags, err_count); end
    $display("[TB] 20 wait cycles: one timeout pulse, xfer_count=%0d", xfer_count);
  endtask

  task automatic test_multi_sel();
    apply_reset();
    bus.PSEL = 4'b0011; bus.PENABLE = 1'b1;
    tick();
    n_tests++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin n_fail++;
      $display("FAIL multi_code: got valid %0b code %0d want 1 1", err_valid, err_code); end
    n_tests++; if (err_flags !== 6'b001010) begin n_fail++; $display("FAIL multi_flags: got %b want 001010", err_flags); end
    n_tests++; if (err_count !== 4'd1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL multi_count: got count %0d busy %0b want 1 0", err_count, busy); end
    bus_idle();
    tick();
    $display("[TB] PSEL=0011 with PENABLE in idle: err_code=1");
  endtask

  task automatic test_no_enable();
    apply_reset();
    bus_setup(4'b0100, 32'h30, 1'b1, 32'h55);
    tick();
    tick();
    n_tests++; if (err_valid !== 1'b1 || err_code !== 3'd2 || err_flags !== 6'b000100) begin n_fail++;
      $display("FAIL noenable_err: got valid %0b code %0d flags %b want 1 2 000100", err_valid, err_code, err_flags); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL noenable_busy: got %0b want 1", busy); end
    bus.PENABLE = 1'b1; bus.PREADY = 1'b1;
    tick();
    n_tests++; if (xfer_count !== 4'd1 || err_valid !== 1'b0) begin n_fail++;
      $display("FAIL noenable_recover: got xfer %0d valid %0b want 1 0", xfer_count, err_valid); end
    bus_idle();
    tick();
    $display("[TB] setup without enable: err_code=2 then recaptured transfer");
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.PENABLE = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_tests++; if (err_count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d want 15", err_count); end
    n_tests++; if (err_flags !== 6'b000001 || err_code !== 3'd0) begin n_fail++;
      $display("FAIL sat_flags: got flags %b code %0d want 000001 0", err_flags, err_code); end
    bus_idle();
    tick();
    bus.PSEL = 4'b1100;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus_idle();
    n_tests++; if (err_count !== 4'd1 || err_flags !== 6'b000010) begin n_fail++;
      $display("FAIL clear_retain: got count %0d flags %b want 1 000010", err_count, err_flags); end
    tick();
    $display("[TB] 20 enable-without-select cycles: err_count saturated");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus_setup(4'b0001, 32'h100, 1'b1, 32'hA);
    tick();
    bus.PENABLE = 1'b1; bus.PREADY = 1'b1;
    tick();
    bus_setup(4'b0001, 32'h104, 1'b1, 32'hB);
    tick();
    n_tests++; if (busy !== 1'b1 || xfer_count !== 4'd1) begin n_fail++;
      $display("FAIL b2b_first: got busy %0b xfer %0d want 1 1", busy, xfer_count); end
    bus.PENABLE = 1'b1; bus.PREADY = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++; if (xfer_count !== 4'd1) begin n_fail++; $display("FAIL b2b_clear_xfer: got %0d want 1", xfer_count); end
    n_tests++; if (err_flags !== 6'b0) begin n_fail++; $display("FAIL b2b_flags: got %b want 000000", err_flags); end
    bus_setup(4'b0010, 32'h108, 1'b0, 32'h0);
    tick();
    bus.PENABLE = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_third_busy: got %0b want 1", busy); end
    HRESET = 1'b1;
    tick();
    n_tests++; if (xfer_count !== 4'd0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_reset: got xfer %0d busy %0b want 0 0", xfer_count, busy); end
    HRESET = 1'b0;
    bus_idle();
    tick();
    n_tests++; if (err_flags !== 6'b0 || err_valid !== 1'b0 || err_count !== 4'd0 || xfer_count !== 4'd0) begin n_fail++;
      $display("FAIL b2b_after_reset: got flags %b valid %0b errs %0d xfer %0d want 000000 0 0 0",
               err_flags, err_valid, err_count, xfer_count); end
    $display("[TB] back-to-back with clear and mid-transfer reset");
  endtask

  initial begin
    bus.PADDR  = '0;
    bus.PWRITE = 1'b0;
    bus.PWDATA = '0;
    bus_idle();
    clear  = 1'b0;
    HRESET = 1'b1;
    test_reset();
    test_write();
    test_read_wait();
    test_unstable();
    test_timeout();
    test_multi_sel();
    test_no_enable();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
